write_engine: RTL and testbench

WRITE_ENGINE -- requirements
Module: write_engine

---
 rtl/cu_pkg.sv | 25 ++
 rtl/globals_cu_pkg.sv | 11 +
 rtl/write_engine_pkg.sv | 58 +++++
 rtl/write_engine_if.sv | 33 +++
 rtl/write_credit_counter.sv | 32 +++
 rtl/write_engine.sv | 165 ++++++++++++++++
 tb/tb_write_engine.sv | 281 ++++++++++++++++++++++++++++
 7 files changed

// File: rtl/cu_pkg.sv
// Compute-unit enums: write engine FSM states, CAPI command and response codes.
package cu_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_WED = 3'd1,
        ISSUE    = 3'd2,
        DRAIN    = 3'd3,
        DONE     = 3'd4
    } write_state_t;

    typedef enum logic [12:0] {
        WRITE_NA = 13'h0D00
    } command_t;

    typedef enum logic [7:0] {
        RSP_DONE   = 8'h00,
        RSP_AERROR = 8'h01,
        RSP_DERROR = 8'h03,
        RSP_FAULT  = 8'h07,
        RSP_FAILED = 8'h08,
        RSP_PAGED  = 8'h0A
    } response_t;

endpackage

// File: rtl/globals_cu_pkg.sv
// Identifiers and widths shared by every compute unit in the accelerator.
package globals_cu_pkg;

    localparam int ARRAY_SIZE_BITS = 32;
    localparam int CU_ID_BITS      = 8;

    typedef logic [CU_ID_BITS-1:0] cu_id_t;

    localparam cu_id_t DATA_WRITE_CONTROL_ID = 8'h12;

endpackage

// File: rtl/write_engine_pkg.sv
// Bus structures and job arithmetic helpers for the write engine.
package write_engine_pkg;
    import globals_cu_pkg::*;
    import cu_pkg::*;

    localparam int LINE_BITS = ARRAY_SIZE_BITS - 5;
    localparam logic [ARRAY_SIZE_BITS-1:0] ELEMENTS_PER_LINE = 32'd32;
    localparam logic [11:0] LINE_BYTES = 12'd128;

    typedef struct packed {
        logic                       valid;
        logic [63:0]                array_receive;
        logic [ARRAY_SIZE_BITS-1:0] size;
    } WEDInterface;

    typedef struct packed {
        logic         valid;
        logic [511:0] data;
    } ReadWriteDataLine;

    typedef struct packed {
        logic      valid;
        response_t response;
        cu_id_t    cu_id;
    } ResponseBufferLine;

    typedef struct packed {
        logic alfull;
        logic full;
    } BufferStatus;

    typedef struct packed {
        logic        valid;
        command_t    command;
        logic [63:0] address;
        logic [11:0] size;
        cu_id_t      cu_id;
    } CommandBufferLine;

    // Cachelines needed for a job; computed without widening the size field.
    function automatic logic [LINE_BITS-1:0] lines_for(input logic [ARRAY_SIZE_BITS-1:0] size);
        return size[ARRAY_SIZE_BITS-1:5] + {{(LINE_BITS-1){1'b0}}, |size[4:0]};
    endfunction

    function automatic logic [ARRAY_SIZE_BITS-1:0] retire_amount(
        input logic [ARRAY_SIZE_BITS-1:0] size,
        input logic [ARRAY_SIZE_BITS-1:0] done
    );
        logic [ARRAY_SIZE_BITS-1:0] left;
        left = size - done;
        if (left > ELEMENTS_PER_LINE) begin
            return ELEMENTS_PER_LINE;
        end else begin
            return left;
        end
    endfunction

endpackage

// File: rtl/write_engine_if.sv
// Job, data, response and command signals of one write engine; master is the engine side.
interface write_engine_if;
    import globals_cu_pkg::*;
    import write_engine_pkg::*;

    logic                       write_enabled_in;
    WEDInterface                wed_request_in;
    ReadWriteDataLine           write_data_0_in;
    ReadWriteDataLine           write_data_1_in;
    ResponseBufferLine          write_response_in;
    BufferStatus                write_command_buffer_status;
    logic                       write_data_ready_out;
    CommandBufferLine           write_command_out;
    ReadWriteDataLine           write_data_0_out;
    ReadWriteDataLine           write_data_1_out;
    logic [ARRAY_SIZE_BITS-1:0] write_job_counter_done;
    logic                       write_error_out;

    modport master (
        input  write_enabled_in, wed_request_in, write_data_0_in, write_data_1_in,
        input  write_response_in, write_command_buffer_status,
        output write_data_ready_out, write_command_out, write_data_0_out, write_data_1_out,
        output write_job_counter_done, write_error_out
    );

    modport slave (
        output write_enabled_in, wed_request_in, write_data_0_in, write_data_1_in,
        output write_response_in, write_command_buffer_status,
        input  write_data_ready_out, write_command_out, write_data_0_out, write_data_1_out,
        input  write_job_counter_done, write_error_out
    );

endinterface

// File: rtl/write_credit_counter.sv
// Up/down count of write commands issued but not yet acknowledged.
module write_credit_counter #(
    parameter int MAX_COUNT = 32,
    parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             available
);
    logic [CNT_W-1:0] count_r;

    // Simultaneous issue and retire cancel out; retire never wraps below zero.
    always_ff @(posedge clock) begin
        if (rst || clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && !dec) begin
            count_r <= count_r + CNT_W'(1);
        end else if (dec && !inc && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count     = count_r;
    assign available = (count_r < CNT_W'(MAX_COUNT));

endmodule

// File: rtl/write_engine.sv
// Streams a job's cachelines out as WRITE_NA commands and counts acknowledged elements.
module write_engine
    import globals_cu_pkg::*;
    import cu_pkg::*;
    import write_engine_pkg::*;
#(
    parameter cu_id_t CU_WRITE_CONTROL_ID = DATA_WRITE_CONTROL_ID,
    parameter int     MAX_OUTSTANDING     = 32
) (
    input logic            clock,
    input logic            rst,
    write_engine_if.master bus
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    write_state_t               state_r;
    write_state_t               state_next_s;
    logic [63:0]                base_r;
    logic [ARRAY_SIZE_BITS-1:0] size_r;
    logic [ARRAY_SIZE_BITS-1:0] done_count_r;
    logic [LINE_BITS-1:0]       total_lines_r;
    logic [LINE_BITS-1:0]       lines_issued_r;
    logic                       error_r;
    logic                       ready_s;
    logic                       consume_s;
    logic                       resp_hit_s;
    logic                       wed_take_s;
    logic                       credit_ok_s;
    logic [CNT_W-1:0]           outstanding_s;
    CommandBufferLine           cmd_r;
    ReadWriteDataLine           data_0_r;
    ReadWriteDataLine           data_1_r;

    assign wed_take_s = (state_r == WAIT_WED) && bus.wed_request_in.valid;
    assign consume_s  = ready_s && bus.write_data_0_in.valid;
    // Responses only retire lines while a job is in flight; foreign cu_ids are not ours.
    assign resp_hit_s = bus.write_response_in.valid
                        && (bus.write_response_in.cu_id == CU_WRITE_CONTROL_ID)
                        && ((state_r == ISSUE) || (state_r == DRAIN));

    write_credit_counter #(
        .MAX_COUNT (MAX_OUTSTANDING),
        .CNT_W     (CNT_W)
    ) credit_u (
        .clock     (clock),
        .rst       (rst),
        .clear     (wed_take_s),
        .inc       (consume_s),
        .dec       (resp_hit_s),
        .count     (outstanding_s),
        .available (credit_ok_s)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.write_enabled_in) state_next_s = WAIT_WED;
                else                      state_next_s = IDLE;
            end
            WAIT_WED: begin
                if (!bus.wed_request_in.valid)                                state_next_s = WAIT_WED;
                else if (bus.wed_request_in.size == {ARRAY_SIZE_BITS{1'b0}}) state_next_s = DONE;
                else                                                          state_next_s = ISSUE;
            end
            ISSUE: begin
                if (lines_issued_r == total_lines_r) state_next_s = DRAIN;
                else                                 state_next_s = ISSUE;
            end
            DRAIN: begin
                if (outstanding_s == {CNT_W{1'b0}}) state_next_s = DONE;
                else                                state_next_s = DRAIN;
            end
            DONE: begin
                if (!bus.write_enabled_in) state_next_s = IDLE;
                else                       state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Line acceptance: the ready has to follow enable and buffer status in the same cycle.
    always_comb begin
        ready_s = 1'b0;
        if (!rst && (state_r == ISSUE) && bus.write_enabled_in
            && !bus.write_command_buffer_status.alfull && !bus.write_command_buffer_status.full
            && credit_ok_s && (lines_issued_r < total_lines_r)) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
    end

    // Job descriptor latch plus issued-line and acknowledged-element counters.
    always_ff @(posedge clock) begin
        if (rst) begin
            base_r         <= 64'd0;
            size_r         <= {ARRAY_SIZE_BITS{1'b0}};
            total_lines_r  <= {LINE_BITS{1'b0}};
            lines_issued_r <= {LINE_BITS{1'b0}};
            done_count_r   <= {ARRAY_SIZE_BITS{1'b0}};
        end else if (wed_take_s) begin
            base_r         <= bus.wed_request_in.array_receive;
            size_r         <= bus.wed_request_in.size;
            total_lines_r  <= lines_for(bus.wed_request_in.size);
            lines_issued_r <= {LINE_BITS{1'b0}};
            done_count_r   <= {ARRAY_SIZE_BITS{1'b0}};
        end else begin
            if (consume_s) lines_issued_r <= lines_issued_r + LINE_BITS'(1);
            else           lines_issued_r <= lines_issued_r;
            if (resp_hit_s) done_count_r <= done_count_r + retire_amount(size_r, done_count_r);
            else            done_count_r <= done_count_r;
        end
    end

    // Sticky error flag for any non-DONE response of ours.
    always_ff @(posedge clock) begin
        if (rst) begin
            error_r <= 1'b0;
        end else if (resp_hit_s && (bus.write_response_in.response != RSP_DONE)) begin
            error_r <= 1'b1;
        end else begin
            error_r <= error_r;
        end
    end

    // Registered command and data; a partial last line still goes out as a full cacheline.
    always_ff @(posedge clock) begin
        if (rst) begin
            cmd_r    <= '0;
            data_0_r <= '0;
            data_1_r <= '0;
        end else if (consume_s) begin
            cmd_r.valid   <= 1'b1;
            cmd_r.command <= WRITE_NA;
            cmd_r.address <= base_r + 64'({lines_issued_r, 7'd0});
            cmd_r.size    <= LINE_BYTES;
            cmd_r.cu_id   <= CU_WRITE_CONTROL_ID;
            data_0_r      <= bus.write_data_0_in;
            data_1_r      <= bus.write_data_1_in;
        end else begin
            cmd_r    <= '0;
            data_0_r <= '0;
            data_1_r <= '0;
        end
    end

    assign bus.write_data_ready_out   = ready_s;
    assign bus.write_command_out      = cmd_r;
    assign bus.write_data_0_out       = data_0_r;
    assign bus.write_data_1_out       = data_1_r;
    assign bus.write_job_counter_done = done_count_r;
    assign bus.write_error_out        = error_r;

endmodule

// File: tb/tb_write_engine.sv
// Directed bench for write_engine with a queue of expected commands checked as they appear.
module tb_write_engine;
    import globals_cu_pkg::*;
    import cu_pkg::*;
    import write_engine_pkg::*;

    typedef struct packed {
        CommandBufferLine cmd;
        ReadWriteDataLine d0;
        ReadWriteDataLine d1;
    } exp_t;

    logic   clock = 1'b0;
    logic   rst;
    int     n_checks = 0;
    int     n_fail = 0;
    int     cmd_count = 0;
    bit     mon_en = 1'b0;
    exp_t   exp_q[$];

    write_engine_if bus ();

    write_engine #(
        .CU_WRITE_CONTROL_ID (DATA_WRITE_CONTROL_ID),
        .MAX_OUTSTANDING     (32)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_line(input logic [63:0] addr);
        exp_t e;
        e.cmd = '{valid: 1'b1, command: WRITE_NA, address: addr, size: 12'd128, cu_id: DATA_WRITE_CONTROL_ID};
        e.d0  = '{valid: 1'b1, data: rand_line()};
        e.d1  = '{valid: 1'b1, data: rand_line()};
        bus.write_data_0_in = e.d0;
        bus.write_data_1_in = e.d1;
        exp_q.push_back(e);
    endtask

    task automatic wait_consume(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (bus.write_data_ready_out === 1'b1) ok = 1'b1;
        end
        if (!ok) void'(exp_q.pop_back());
        @(posedge clock);
        #1;
        bus.write_data_0_in = '0;
        bus.write_data_1_in = '0;
        check(tag, ok, 1'b1);
    endtask

    task automatic send_line(input logic [63:0] addr, input string tag);
        drive_line(addr);
        wait_consume(tag);
    endtask

    task automatic send_resp(input response_t code, input cu_id_t id);
        bus.write_response_in = '{valid: 1'b1, response: code, cu_id: id};
        @(posedge clock);
        #1;
        bus.write_response_in = '0;
    endtask

    task automatic start_job(input logic [63:0] base, input logic [31:0] size);
        bus.write_enabled_in = 1'b1;
        bus.wed_request_in   = '{valid: 1'b1, array_receive: base, size: size};
        wait_cycles(2);
        bus.wed_request_in   = '0;
    endtask

    task automatic end_job();
        bus.write_enabled_in = 1'b0;
        wait_cycles(1);
    endtask

    // Command monitor: every issued command must match the oldest expected line.
    always @(negedge clock) begin
        if (mon_en) begin
            if (bus.write_command_out.valid === 1'b1) begin
                cmd_count++;
                check("cmd_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("cmd_fields", bus.write_command_out, e.cmd);
                    check("cmd_data0", bus.write_data_0_out, e.d0);
                    check("cmd_data1", bus.write_data_1_out, e.d1);
                end
            end else begin
                check("idle_data_valid", {bus.write_data_0_out.valid, bus.write_data_1_out.valid}, 2'b00);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        rst                             = 1'b1;
        bus.write_enabled_in            = 1'b0;
        bus.wed_request_in              = '0;
        bus.write_data_0_in             = '0;
        bus.write_data_1_in             = '0;
        bus.write_response_in           = '0;
        bus.write_command_buffer_status = '0;
        wait_cycles(3);
        rst    = 1'b0;
        mon_en = 1'b1;
        check("rst_state", dut.state_r, IDLE);
        check("rst_ready", bus.write_data_ready_out, 1'b0);
        check("rst_cmd_valid", bus.write_command_out.valid, 1'b0);
        check("rst_done", bus.write_job_counter_done, 32'd0);
        check("rst_error", bus.write_error_out, 1'b0);

        // Two full lines at 0x1000.
        start_job(64'h1000, 32'd64);
        check("t1_state_issue", dut.state_r, ISSUE);
        send_line(64'h1000, "t1_line0");
        send_line(64'h1080, "t1_line1");
        wait_cycles(1);
        check("t1_state_drain", dut.state_r, DRAIN);
        check("t1_outstanding", dut.outstanding_s, 6'd2);
        send_resp(RSP_DONE, DATA_WRITE_CONTROL_ID);
        check("t1_done_32", bus.write_job_counter_done, 32'd32);
        send_resp(RSP_DONE, DATA_WRITE_CONTROL_ID);
        check("t1_done_64", bus.write_job_counter_done, 32'd64);
        wait_cycles(1);
        check("t1_state_done", dut.state_r, DONE);
        wait_cycles(3);
        check("t1_hold_done", dut.state_r, DONE);
        check("t1_hold_count", bus.write_job_counter_done, 32'd64);
        check("t1_error", bus.write_error_out, 1'b0);
        end_job();
        check("t1_state_idle", dut.state_r, IDLE);

        // Empty job goes straight to DONE.
        start_job(64'h3000, 32'd0);
        check("t0_state_done", dut.state_r, DONE);
        check("t0_done_count", bus.write_job_counter_done, 32'd0);
        check("t0_ready", bus.write_data_ready_out, 1'b0);
        end_job();

        // Partial last line: 40 elements.
        start_job(64'h2000, 32'd40);
        send_line(64'h2000, "t2_line0");
        send_line(64'h2080, "t2_line1");
        send_resp(RSP_DONE, DATA_WRITE_CONTROL_ID);
        check("t2_done_32", bus.write_job_counter_done, 32'd32);
        send_resp(RSP_DONE, DATA_WRITE_CONTROL_ID);
        check("t2_done_40", bus.write_job_counter_done, 32'd40);
        wait_cycles(1);
        check("t2_state_done", dut.state_r, DONE);
        end_job();

        // Almost-full back-pressure, then enable dropped mid-job.
        start_job(64'h4000, 32'd96);
        bus.write_command_buffer_status = '{alfull: 1'b1, full: 1'b0};
        drive_line(64'h4000);
        c0 = cmd_count;
        repeat (10) begin
            @(negedge clock);
            check("t3_alfull_ready", bus.write_data_ready_out, 1'b0);
        end
        @(posedge clock);
        #1;
        check("t3_alfull_no_cmd", cmd_count, c0);
        bus.write_command_buffer_status = '0;
        wait_consume("t3_line0");
        bus.write_enabled_in = 1'b0;
        drive_line(64'h4080);
        repeat (3) begin
            @(negedge clock);
            check("t3_disabled_ready", bus.write_data_ready_out, 1'b0);
        end
        @(posedge clock);
        #1;
        send_resp(RSP_DONE, DATA_WRITE_CONTROL_ID);
        check("t3_disabled_count", bus.write_job_counter_done, 32'd32);
        bus.write_enabled_in = 1'b1;
        wait_consume("t3_line1");
        send_line(64'h4100, "t3_line2");
        send_resp(RSP_DONE, DATA_WRITE_CONTROL_ID);
        send_resp(RSP_DONE, DATA_WRITE_CONTROL_ID);
        check("t3_done_96", bus.write_job_counter_done, 32'd96);
        wait_cycles(1);
        check("t3_state_done", dut.state_r, DONE);
        end_job();

        // Credit limit: 34 lines, 32 in flight at most.
        start_job(64'h10000, 32'd1088);
        for (int i = 0; i < 32; i++) send_line(64'h10000 + 64'(i) * 64'd128, "t4_line");
        check("t4_outstanding_max", dut.outstanding_s, 6'd32);
        drive_line(64'h11000);
        repeat (3) begin
            @(negedge clock);
            check("t4_credit_ready", bus.write_data_ready_out, 1'b0);
        end
        @(posedge clock);
        #1;
        send_resp(RSP_DONE, DATA_WRITE_CONTROL_ID);
        wait_consume("t4_line32");
        drive_line(64'h11080);
        repeat (3) begin
            @(negedge clock);
            check("t4_credit_ready2", bus.write_data_ready_out, 1'b0);
        end
        @(posedge clock);
        #1;
        check("t4_outstanding_max2", dut.outstanding_s, 6'd32);
        send_resp(RSP_DONE, DATA_WRITE_CONTROL_ID);
        wait_consume("t4_line33");
        for (int i = 0; i < 32; i++) send_resp(RSP_DONE, DATA_WRITE_CONTROL_ID);
        check("t4_done_1088", bus.write_job_counter_done, 32'd1088);
        wait_cycles(1);
        check("t4_state_done", dut.state_r, DONE);
        end_job();

        // FAULT response and a foreign cu_id response.
        start_job(64'h20000, 32'd64);
        send_line(64'h20000, "t5_line0");
        send_line(64'h20080, "t5_line1");
        send_resp(RSP_FAULT, DATA_WRITE_CONTROL_ID);
        check("t5_error_set", bus.write_error_out, 1'b1);
        check("t5_fault_retired", bus.write_job_counter_done, 32'd32);
        send_resp(RSP_DONE, 8'h3C);
        check("t5_foreign_ignored", bus.write_job_counter_done, 32'd32);
        wait_cycles(1);
        check("t5_state_drain", dut.state_r, DRAIN);
        check("t5_outstanding", dut.outstanding_s, 6'd1);
        check("t5_error_sticky", bus.write_error_out, 1'b1);

        // Reset while draining abandons the job.
        rst = 1'b1;
        wait_cycles(1);
        check("t6_state_idle", dut.state_r, IDLE);
        check("t6_ready", bus.write_data_ready_out, 1'b0);
        check("t6_cmd_valid", bus.write_command_out.valid, 1'b0);
        check("t6_data_valid", {bus.write_data_0_out.valid, bus.write_data_1_out.valid}, 2'b00);
        check("t6_done", bus.write_job_counter_done, 32'd0);
        check("t6_error", bus.write_error_out, 1'b0);
        check("t6_outstanding", dut.outstanding_s, 6'd0);
        rst = 1'b0;
        bus.write_enabled_in = 1'b0;
        wait_cycles(2);
        check("all_lines_issued", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
